// File: rtl/reduce_stream.sv
// reduce_stream: reduces every bit of every beat of a packet to a single
// result bit (OR / AND / XOR / NOR). It reports the result together with the
// number of beats in the packet. A packet is force-terminated at MAXLEN beats
// if in_last has not arrived by then.
module reduce_stream #(
  parameter int WIDTH  = 4,
  parameter int MAXLEN = 16,
  localparam int CNTW  = $clog2(MAXLEN + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_result,
  output logic [CNTW-1:0]  out_count,
  output logic             out_overflow
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ACCUM = 2'b01,
    HOLD  = 2'b10
  } state_t;

  localparam logic [1:0] MODE_OR  = 2'b00;
  localparam logic [1:0] MODE_AND = 2'b01;
  localparam logic [1:0] MODE_XOR = 2'b10;
  localparam logic [1:0] MODE_NOR = 2'b11;

  state_t            state;
  state_t            state_next;
  logic [1:0]        mode_q;
  logic              acc;
  logic [CNTW-1:0]   count;

  logic              accept;
  logic [1:0]        eff_mode;
  logic              word_r;
  logic              next_acc;
  logic [CNTW-1:0]   next_count;
  logic              terminal;

  // The block only stalls the input while a finished result is waiting.
  assign in_ready = (state != HOLD);
  assign accept   = in_valid & in_ready;

  // The first beat of a packet uses the live mode; later beats use the copy
  // latched on that first beat, so mid-packet mode changes are ignored.
  assign eff_mode = (state == IDLE) ? mode : mode_q;

  // Reduce the incoming word to one bit; NOR reduces with OR and is inverted
  // only when the final result is presented.
  always_comb begin
    word_r = 1'b0;
    case (eff_mode)
      MODE_OR:  word_r = |in_data;
      MODE_AND: word_r = &in_data;
      MODE_XOR: word_r = ^in_data;
      MODE_NOR: word_r = |in_data;
      default:  word_r = |in_data;
    endcase
  end

  // Fold the word reduction into the running accumulator and beat count.
  always_comb begin
    next_acc   = word_r;
    next_count = CNTW'(1);
    if (state == ACCUM) begin
      next_count = count + CNTW'(1);
      case (mode_q)
        MODE_OR:  next_acc = acc | word_r;
        MODE_AND: next_acc = acc & word_r;
        MODE_XOR: next_acc = acc ^ word_r;
        MODE_NOR: next_acc = acc | word_r;
        default:  next_acc = acc | word_r;
      endcase
    end
  end

  // A beat ends the packet on in_last or when it is the MAXLEN-th beat.
  assign terminal = in_last | (next_count == CNTW'(MAXLEN));

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: accepted beats move towards HOLD, a handshake leaves it.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = terminal ? HOLD : ACCUM;
        end
      end
      ACCUM: begin
        if (accept && terminal) begin
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (out_valid && out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Accumulator, beat counter, latched mode and the registered result.
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q       <= MODE_OR;
      acc          <= 1'b0;
      count        <= '0;
      out_valid    <= 1'b0;
      out_result   <= 1'b0;
      out_count    <= '0;
      out_overflow <= 1'b0;
    end else if (accept) begin
      acc   <= next_acc;
      count <= next_count;
      if (state == IDLE) begin
        mode_q <= mode;
      end
      if (terminal) begin
        out_valid    <= 1'b1;
        out_result   <= (eff_mode == MODE_NOR) ? ~next_acc : next_acc;
        out_count    <= next_count;
        out_overflow <= ~in_last;
      end
    end else if ((state == HOLD) && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_reduce_stream.sv
// Directed testbench for reduce_stream (WIDTH=4, MAXLEN=4), with a second
// MAXLEN=1 instance for the single-beat-packet corner case.
module tb_reduce_stream;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] mode;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic       out_result;
  logic [2:0] out_count;
  logic       out_overflow;

  logic       m1_in_valid;
  logic       m1_in_ready;
  logic [3:0] m1_in_data;
  logic       m1_in_last;
  logic       m1_out_valid;
  logic       m1_out_ready;
  logic       m1_out_result;
  logic [0:0] m1_out_count;
  logic       m1_out_overflow;

  int checks   = 0;
  int failures = 0;

  reduce_stream #(.WIDTH(4), .MAXLEN(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .mode         (mode),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_last      (in_last),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_count    (out_count),
    .out_overflow (out_overflow)
  );

  reduce_stream #(.WIDTH(4), .MAXLEN(1)) dut_m1 (
    .clk          (clk),
    .reset        (reset),
    .mode         (mode),
    .in_valid     (m1_in_valid),
    .in_ready     (m1_in_ready),
    .in_data      (m1_in_data),
    .in_last      (m1_in_last),
    .out_valid    (m1_out_valid),
    .out_ready    (m1_out_ready),
    .out_result   (m1_out_result),
    .out_count    (m1_out_count),
    .out_overflow (m1_out_overflow)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one beat for exactly one edge; the block must be ready for it.
  task automatic applyStimulus(input logic [3:0] d, input logic last, input logic [1:0] m);
    checkOutput("beat_in_ready", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    mode     = m;
    tick();
    in_valid = 1'b0;
    in_data  = 4'd0;
    in_last  = 1'b0;
  endtask

  // Check a presented result, consume it, and check the block returns to idle.
  task automatic expectResult(input string tag, input logic res, input logic [2:0] cnt, input logic ovf);
    checkOutput({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    checkOutput({tag, "_hold_ready"}, {31'd0, in_ready}, 32'd0);
    checkOutput({tag, "_result"}, {31'd0, out_result}, {31'd0, res});
    checkOutput({tag, "_count"}, {29'd0, out_count}, {29'd0, cnt});
    checkOutput({tag, "_overflow"}, {31'd0, out_overflow}, {31'd0, ovf});
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checkOutput({tag, "_consumed"}, {31'd0, out_valid}, 32'd0);
    checkOutput({tag, "_ready_after"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    reset        = 1'b1;
    mode         = 2'b00;
    in_valid     = 1'b0;
    in_data      = 4'd0;
    in_last      = 1'b0;
    out_ready    = 1'b0;
    m1_in_valid  = 1'b0;
    m1_in_data   = 4'd0;
    m1_in_last   = 1'b0;
    m1_out_ready = 1'b0;

    // Reset state.
    tick();
    tick();
    checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_out_result", {31'd0, out_result}, 32'd0);
    checkOutput("rst_out_count", {29'd0, out_count}, 32'd0);
    checkOutput("rst_out_overflow", {31'd0, out_overflow}, 32'd0);
    reset = 1'b0;
    #1;
    checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Exhaustive single-beat OR.
    for (int d = 0; d < 16; d++) begin
      applyStimulus(4'(d), 1'b1, 2'b00);
      expectResult($sformatf("or1_%0d", d), (d != 0), 3'd1, 1'b0);
    end

    // AND packets.
    applyStimulus(4'hF, 1'b0, 2'b01);
    applyStimulus(4'hF, 1'b0, 2'b01);
    applyStimulus(4'h7, 1'b1, 2'b01);
    expectResult("and_mixed", 1'b0, 3'd3, 1'b0);
    applyStimulus(4'hF, 1'b0, 2'b01);
    applyStimulus(4'hF, 1'b0, 2'b01);
    applyStimulus(4'hF, 1'b1, 2'b01);
    expectResult("and_ones", 1'b1, 3'd3, 1'b0);

    // Mode change after the first beat is ignored (AND kept, OR would give 1).
    applyStimulus(4'hF, 1'b0, 2'b01);
    applyStimulus(4'h1, 1'b1, 2'b00);
    expectResult("mode_latch", 1'b0, 3'd2, 1'b0);

    // XOR and NOR packets.
    applyStimulus(4'h1, 1'b0, 2'b10);
    applyStimulus(4'h3, 1'b1, 2'b10);
    expectResult("xor", 1'b1, 3'd2, 1'b0);
    applyStimulus(4'h0, 1'b0, 2'b11);
    applyStimulus(4'h0, 1'b1, 2'b11);
    expectResult("nor_zero", 1'b1, 3'd2, 1'b0);
    applyStimulus(4'h0, 1'b0, 2'b11);
    applyStimulus(4'h4, 1'b1, 2'b11);
    expectResult("nor_one", 1'b0, 3'd2, 1'b0);

    // Overflow at MAXLEN=4; the fifth beat starts a new packet.
    applyStimulus(4'h0, 1'b0, 2'b00);
    applyStimulus(4'h0, 1'b0, 2'b00);
    applyStimulus(4'h0, 1'b0, 2'b00);
    applyStimulus(4'h8, 1'b0, 2'b00);
    expectResult("ovf", 1'b1, 3'd4, 1'b1);
    applyStimulus(4'h0, 1'b0, 2'b00);
    applyStimulus(4'h0, 1'b1, 2'b00);
    expectResult("ovf_next", 1'b0, 3'd2, 1'b0);

    // Idle cycles inside a packet do not disturb the accumulator.
    applyStimulus(4'h8, 1'b0, 2'b10);
    tick();
    tick();
    tick();
    checkOutput("idle_no_valid", {31'd0, out_valid}, 32'd0);
    applyStimulus(4'h8, 1'b1, 2'b10);
    expectResult("idle_xor", 1'b0, 3'd2, 1'b0);

    // Backpressure: result held, input stalled, stray beat ignored.
    applyStimulus(4'h5, 1'b1, 2'b00);
    in_valid = 1'b1;
    in_data  = 4'h0;
    in_last  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checkOutput("bp_valid", {31'd0, out_valid}, 32'd1);
      checkOutput("bp_in_ready", {31'd0, in_ready}, 32'd0);
      checkOutput("bp_result", {31'd0, out_result}, 32'd1);
      checkOutput("bp_count", {29'd0, out_count}, 32'd1);
      checkOutput("bp_overflow", {31'd0, out_overflow}, 32'd0);
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    expectResult("bp", 1'b1, 3'd1, 1'b0);
    tick();
    checkOutput("bp_single", {31'd0, out_valid}, 32'd0);

    // Reset discards a partial packet.
    applyStimulus(4'hF, 1'b0, 2'b01);
    applyStimulus(4'h0, 1'b0, 2'b01);
    reset = 1'b1;
    tick();
    checkOutput("rstmid_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rstmid_count", {29'd0, out_count}, 32'd0);
    reset = 1'b0;
    #1;
    checkOutput("rstmid_ready", {31'd0, in_ready}, 32'd1);
    applyStimulus(4'hF, 1'b1, 2'b01);
    expectResult("rstmid_and", 1'b1, 3'd1, 1'b0);

    // Reset discards an unconsumed result, overriding a simultaneous handshake.
    applyStimulus(4'hF, 1'b1, 2'b00);
    reset     = 1'b1;
    out_ready = 1'b1;
    tick();
    reset     = 1'b0;
    out_ready = 1'b0;
    checkOutput("rsthold_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rsthold_result", {31'd0, out_result}, 32'd0);
    checkOutput("rsthold_ready", {31'd0, in_ready}, 32'd1);

    // MAXLEN=1: every beat terminal, overflow flags a missing in_last.
    m1_in_valid = 1'b1;
    m1_in_data  = 4'h1;
    m1_in_last  = 1'b0;
    mode        = 2'b00;
    tick();
    m1_in_valid = 1'b0;
    checkOutput("m1_valid", {31'd0, m1_out_valid}, 32'd1);
    checkOutput("m1_result", {31'd0, m1_out_result}, 32'd1);
    checkOutput("m1_count", {31'd0, m1_out_count}, 32'd1);
    checkOutput("m1_overflow", {31'd0, m1_out_overflow}, 32'd1);
    checkOutput("m1_hold_ready", {31'd0, m1_in_ready}, 32'd0);
    m1_out_ready = 1'b1;
    tick();
    m1_out_ready = 1'b0;
    checkOutput("m1_consumed", {31'd0, m1_out_valid}, 32'd0);
    m1_in_valid = 1'b1;
    m1_in_data  = 4'h0;
    m1_in_last  = 1'b1;
    tick();
    m1_in_valid = 1'b0;
    m1_in_last  = 1'b0;
    checkOutput("m1_last_valid", {31'd0, m1_out_valid}, 32'd1);
    checkOutput("m1_last_result", {31'd0, m1_out_result}, 32'd0);
    checkOutput("m1_last_overflow", {31'd0, m1_out_overflow}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
